// File: rtl/fft_output_reorder_if.sv
// Stream bundle for the FFT output reorder buffer: digit-reversed samples in,
// natural-order samples out, each side with its own valid/ready handshake.
interface fft_output_reorder_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic [3:0]        out_idx;
  logic              out_last;

  // Producer of input samples / consumer of results (the surrounding datapath).
  modport master (
    output in_valid, in_re, in_im, in_last, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  // The reorder buffer itself.
  modport slave (
    input  in_valid, in_re, in_im, in_last, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft_output_reorder.sv
// Reorder buffer for the 16-point radix-4 FFT: samples arrive in digit-reversed
// order, are written to a ping-pong bank at their arrival index, and are read
// back in natural bin order by swapping the two base-4 digits of the bin number.
module fft_output_reorder #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  fft_output_reorder_if.slave bus,
  output logic                frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM} state_e;

  logic [2*DATA_W-1:0] mem_q [2][16];

  state_e            state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [3:0]        idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_err_q, frame_err_d;
  logic [DATA_W-1:0] out_re_q, out_re_d;
  logic [DATA_W-1:0] out_im_q, out_im_d;

  logic                in_fire;
  logic                out_fire;
  logic [3:0]          rd_bin;
  logic [3:0]          rd_entry;
  logic [2*DATA_W-1:0] rd_word;

  assign bus.in_ready = rst_n && !flush && !full_q[wptr_q];
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid_q && bus.out_ready;

  // Bin about to be loaded: 0 from LOAD, otherwise the successor of the current bin.
  assign rd_bin   = (state_q == ST_STREAM) ? idx_q + 4'd1 : 4'd0;
  assign rd_entry = {rd_bin[1:0], rd_bin[3:2]};
  assign rd_word  = mem_q[rptr_q][rd_entry];

  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = out_last_q;
  assign frame_err     = frame_err_q;

  // Next-state: fill-side counters, bank flags and the drain FSM with its output registers.
  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    wcnt_d      = wcnt_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    frame_err_d = 1'b0;

    if (in_fire) begin
      frame_err_d = bus.in_last ^ (wcnt_q == 4'd15);
      wcnt_d      = wcnt_q + 4'd1;
      if (wcnt_q == 4'd15) begin
        full_d[wptr_q] = 1'b1;
        wptr_d         = ~wptr_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (full_q[rptr_q]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        out_valid_d = 1'b1;
        idx_d       = 4'd0;
        out_last_d  = 1'b0;
        out_re_d    = rd_word[2*DATA_W-1:DATA_W];
        out_im_d    = rd_word[DATA_W-1:0];
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        if (out_fire) begin
          if (idx_q != 4'd15) begin
            idx_d      = idx_q + 4'd1;
            out_last_d = (idx_q == 4'd14);
            out_re_d   = rd_word[2*DATA_W-1:DATA_W];
            out_im_d   = rd_word[DATA_W-1:0];
          end else begin
            // The fill side never targets the draining bank, so clearing
            // here cannot collide with a same-edge FULL set on the other bank.
            out_valid_d    = 1'b0;
            out_last_d     = 1'b0;
            full_d[rptr_q] = 1'b0;
            rptr_d         = ~rptr_q;
            state_d        = full_q[~rptr_q] ? ST_LOAD : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d     = ST_IDLE;
      full_d      = '0;
      wptr_d      = 1'b0;
      rptr_d      = 1'b0;
      wcnt_d      = '0;
      idx_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_re_d    = '0;
      out_im_d    = '0;
      frame_err_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      full_q      <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      wcnt_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      wcnt_q      <= wcnt_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Sample storage: accepted sample k of a frame lands at entry k of the fill bank.
  always_ff @(posedge clk) begin
    if (in_fire) mem_q[wptr_q][wcnt_q] <= {bus.in_re, bus.in_im};
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Bench for fft_output_reorder: directed phases with random data and handshakes,
// checked each cycle against a frame-level model of the digit-reversal reorder.
module tb_fft_output_reorder;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic frame_err;

  fft_output_reorder_if #(.DATA_W(DW)) bus ();

  fft_output_reorder #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus.slave),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int unsigned   idx;
  } smp_t;

  smp_t          exp_q[$];
  logic [DW-1:0] part_re[16];
  logic [DW-1:0] part_im[16];
  int            pcnt, full_cnt, frames_done, accepted, ferr_seen;
  bit            exp_ferr;
  bit            seq_mode;
  int            extra_last;
  logic [DW-1:0] cur_re, cur_im;
  bit            prev_ov, prev_or, prev_last;
  logic [DW-1:0] prev_re, prev_im;
  logic [3:0]    prev_idx;
  bit            chk_gap;
  int            since_last, gaps_seen, last_idx_seen;
  int            cmp, bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    cmp++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pcnt       = 0;
    full_cnt   = 0;
    exp_ferr   = 1'b0;
    prev_ov    = 1'b0;
    since_last = -1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_re"}, bus.out_re, 0);
    check({tag, "_out_im"}, bus.out_im, 0);
    check({tag, "_out_idx"}, bus.out_idx, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, update model at posedge.
  task automatic step(input bit iv, input bit ordy, input bit fl);
    bit   in_fire, out_fire;
    smp_t e;
    @(negedge clk);
    if (since_last >= 0) since_last++;
    if (seq_mode) begin
      cur_re = DW'(pcnt);
      cur_im = DW'(-pcnt);
    end
    bus.in_valid  = iv;
    bus.in_re     = cur_re;
    bus.in_im     = cur_im;
    bus.in_last   = (pcnt == 15) || (pcnt == extra_last);
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    check("frame_err", frame_err, exp_ferr);
    if (frame_err) ferr_seen++;
    check("in_ready", bus.in_ready, !fl && (full_cnt < 2));
    if (prev_ov && !prev_or) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_re", bus.out_re, prev_re);
      check("hold_im", bus.out_im, prev_im);
      check("hold_idx", bus.out_idx, prev_idx);
      check("hold_last", bus.out_last, prev_last);
    end
    if (bus.out_valid) begin
      last_idx_seen = int'(bus.out_idx);
      check("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("out_re", bus.out_re, e.re);
        check("out_im", bus.out_im, e.im);
        check("out_idx", bus.out_idx, e.idx);
        check("out_last", bus.out_last, e.idx == 15);
      end
      if (chk_gap && since_last > 0) begin
        check("frame_gap", since_last, 2);
        gaps_seen++;
        since_last = -1;
      end
    end
    prev_ov   = bus.out_valid && !fl;
    prev_or   = ordy;
    prev_re   = bus.out_re;
    prev_im   = bus.out_im;
    prev_idx  = bus.out_idx;
    prev_last = bus.out_last;
    in_fire   = iv && bus.in_ready;
    out_fire  = bus.out_valid && ordy;
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (out_fire && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.idx == 15) begin
          full_cnt--;
          if (chk_gap) since_last = 0;
        end
      end
      exp_ferr = 1'b0;
      if (in_fire) begin
        exp_ferr      = bus.in_last != (pcnt == 15);
        part_re[pcnt] = bus.in_re;
        part_im[pcnt] = bus.in_im;
        accepted++;
        pcnt++;
        if (pcnt == 16) begin
          // Natural bin n sits at arrival position (n mod 4)*4 + n/4.
          for (int n = 0; n < 16; n++) begin
            e.idx = n;
            e.re  = part_re[(n % 4) * 4 + n / 4];
            e.im  = part_im[(n % 4) * 4 + n / 4];
            exp_q.push_back(e);
          end
          full_cnt++;
          frames_done++;
          pcnt = 0;
        end
        if (!seq_mode) begin
          cur_re = DW'($urandom);
          cur_im = DW'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    #1;
    chk_zero("rst");
    check("rst_in_ready", bus.in_ready, 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_n(input int n);
    int target;
    target = accepted + n;
    for (int c = 0; c < 200 && accepted < target; c++) step(1, 1, 0);
    check("send_done", accepted, target);
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) step(0, 1, 0);
    check("drained", exp_q.size(), 0);
    repeat (3) step(0, 1, 0);
  endtask

  task automatic run_to_bin5(input bit use_flush);
    last_idx_seen = -1;
    for (int c = 0; c < 60 && last_idx_seen != 4; c++) step(0, 1, 0);
    check("reached_bin4", last_idx_seen, 4);
    if (use_flush) begin
      step(1, 1, 1);
      #1;
      chk_zero("flush_stream");
    end else begin
      do_reset();
    end
  endtask

  initial begin
    int target;
    cmp = 0; bad = 0;
    frames_done = 0; accepted = 0; ferr_seen = 0;
    seq_mode = 1'b0; extra_last = -1; chk_gap = 1'b0; gaps_seen = 0;
    last_idx_seen = -1;
    cur_re = DW'($urandom); cur_im = DW'($urandom);
    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();

    // Reset state.
    #1;
    chk_zero("init");
    check("init_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: single ordered frame re=k, im=-k.
    seq_mode = 1'b1;
    send_n(16);
    drain();
    seq_mode = 1'b0;

    // 2: three back-to-back frames, exactly one idle output cycle between frames.
    chk_gap = 1'b1;
    gaps_seen = 0;
    target = frames_done + 3;
    for (int c = 0; c < 300 && frames_done < target; c++) step(1, 1, 0);
    check("t2_frames", frames_done, target);
    drain();
    check("t2_gaps", gaps_seen, 2);
    chk_gap = 1'b0;

    // 3: backpressure: consumer stalled while two frames arrive.
    accepted = 0;
    repeat (40) step(1, 0, 0);
    check("t3_accepted", accepted, 32);
    drain();

    // 4: random handshakes on both sides over 100 frames.
    target = frames_done + 100;
    for (int c = 0; c < 20000 && frames_done < target; c++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 0);
    check("t4_frames", frames_done, target);
    drain();

    // 5: early in_last at k=9 pulses frame_err once; framing unaffected.
    ferr_seen  = 0;
    extra_last = 9;
    send_n(16);
    extra_last = -1;
    drain();
    check("t5_ferr_pulses", ferr_seen, 1);

    // 6a: reset after a partial frame, then reset during bin 5.
    send_n(7);
    do_reset();
    send_n(16);
    drain();
    send_n(16);
    run_to_bin5(1'b0);
    send_n(16);
    drain();

    // 6b: the same two cases with flush.
    send_n(7);
    step(1, 1, 1);
    #1;
    chk_zero("flush_partial");
    send_n(16);
    drain();
    send_n(16);
    run_to_bin5(1'b1);
    send_n(16);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
